// File: rtl/sa_pkg.sv
// Shared constants and FSM state encoding for the systolic array, its feeder and benches.
package sa_pkg;

   localparam int unsigned SA_N  = 8;
   localparam int unsigned SA_DW = 8;
   localparam int unsigned SA_CW = 32;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CLEAR,
      S_FEED,
      S_DRAIN,
      S_DONE
   } state_e;

endpackage

// File: rtl/skew_lane.sv
// One diagonal-skew lane: picks vec[t-IDX] while that index is inside the matrix, else zero.
module skew_lane
   import sa_pkg::*;
#(
   parameter int unsigned N   = SA_N,
   parameter int unsigned DW  = SA_DW,
   parameter int unsigned IDX = 0,
   parameter int unsigned TW  = $clog2(2 * N)
) (
   input  logic [TW-1:0]   t,
   input  logic [N*DW-1:0] vec,
   output logic [DW-1:0]   sel_c
);

   logic [TW-1:0] off_c;
   logic          hit_c;

   always_comb begin
      off_c = t - TW'(IDX);
      hit_c = (t >= TW'(IDX)) && (off_c < TW'(N));
      sel_c = '0;
      if (hit_c) begin
         sel_c = vec[off_c*DW +: DW];
      end
   end

endmodule

// File: rtl/systolic_feeder.sv
// Buffers an A/B operand pair, clears the array, streams skewed operands, then holds the
// result-valid flag until the consumer acknowledges.
module systolic_feeder
   import sa_pkg::*;
#(
   parameter int unsigned N     = SA_N,
   parameter int unsigned DW    = SA_DW,
   parameter int unsigned DRAIN = N + 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N*DW-1:0] in_a_col,
   input  logic [N*DW-1:0] in_b_row,
   output logic            arr_clear,
   output logic [N*DW-1:0] arr_a,
   output logic [N*DW-1:0] arr_b,
   output logic            busy,
   output logic            res_valid,
   input  logic            res_ready
);

   localparam int unsigned TW  = $clog2(2 * N);
   localparam int unsigned DCW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
   localparam logic [TW-1:0]  K_LAST = TW'(N - 1);
   localparam logic [TW-1:0]  T_LAST = TW'(2 * N - 2);
   localparam logic [DCW-1:0] D_LAST = DCW'(DRAIN - 1);

   state_e                    state_q, state_d;
   logic [TW-1:0]             k_q, k_d;
   logic [TW-1:0]             t_q, t_d;
   logic [DCW-1:0]            dc_q, dc_d;
   logic                      in_ready_q, in_ready_d;
   logic                      arr_clear_q, arr_clear_d;
   logic                      busy_q, busy_d;
   logic                      res_valid_q, res_valid_d;
   logic [N*DW-1:0]           arr_a_q, arr_a_d;
   logic [N*DW-1:0]           arr_b_q, arr_b_d;
   // a_buf[i] holds row i of A over k; b_buf[j] holds column j of B over k.
   logic [N-1:0][N*DW-1:0]    a_buf_q, a_buf_d;
   logic [N-1:0][N*DW-1:0]    b_buf_q, b_buf_d;
   logic [N*DW-1:0]           lane_a_c, lane_b_c;
   logic                      accept_c;

   assign accept_c = in_valid & in_ready_q;

   for (genvar g = 0; g < int'(N); g++) begin : g_lane
      skew_lane #(.N(N), .DW(DW), .IDX(g), .TW(TW)) u_lane_a (
         .t     (t_d),
         .vec   (a_buf_q[g]),
         .sel_c (lane_a_c[g*DW +: DW])
      );
      skew_lane #(.N(N), .DW(DW), .IDX(g), .TW(TW)) u_lane_b (
         .t     (t_d),
         .vec   (b_buf_q[g]),
         .sel_c (lane_b_c[g*DW +: DW])
      );
   end

   // Next state, counters and buffer writes.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      t_d     = t_q;
      dc_d    = dc_q;
      a_buf_d = a_buf_q;
      b_buf_d = b_buf_q;
      case (state_q)
         S_IDLE, S_LOAD: begin
            if (accept_c) begin
               for (int unsigned i = 0; i < N; i++) begin
                  a_buf_d[i][k_q*DW +: DW] = in_a_col[i*DW +: DW];
                  b_buf_d[i][k_q*DW +: DW] = in_b_row[i*DW +: DW];
               end
               if (k_q == K_LAST) begin
                  state_d = S_CLEAR;
                  k_d     = '0;
               end else begin
                  state_d = S_LOAD;
                  k_d     = k_q + TW'(1);
               end
            end
         end
         S_CLEAR: begin
            state_d = S_FEED;
            t_d     = '0;
         end
         S_FEED: begin
            if (t_q == T_LAST) begin
               state_d = S_DRAIN;
               t_d     = '0;
               dc_d    = '0;
            end else begin
               t_d = t_q + TW'(1);
            end
         end
         S_DRAIN: begin
            if (dc_q == D_LAST) begin
               state_d = S_DONE;
            end else begin
               dc_d = dc_q + DCW'(1);
            end
         end
         S_DONE: begin
            if (res_ready) begin
               state_d = S_IDLE;
               k_d     = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so they register in step with it.
   always_comb begin
      in_ready_d  = (state_d == S_IDLE) || (state_d == S_LOAD);
      busy_d      = !in_ready_d;
      arr_clear_d = (state_d == S_CLEAR);
      res_valid_d = (state_d == S_DONE);
      arr_a_d     = '0;
      arr_b_d     = '0;
      if (state_d == S_FEED) begin
         arr_a_d = lane_a_c;
         arr_b_d = lane_b_c;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         k_q         <= '0;
         t_q         <= '0;
         dc_q        <= '0;
         in_ready_q  <= 1'b1;
         arr_clear_q <= 1'b0;
         busy_q      <= 1'b0;
         res_valid_q <= 1'b0;
         arr_a_q     <= '0;
         arr_b_q     <= '0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         t_q         <= t_d;
         dc_q        <= dc_d;
         in_ready_q  <= in_ready_d;
         arr_clear_q <= arr_clear_d;
         busy_q      <= busy_d;
         res_valid_q <= res_valid_d;
         arr_a_q     <= arr_a_d;
         arr_b_q     <= arr_b_d;
      end
   end

   // Operand storage carries no reset; every job overwrites all of it before use.
   always_ff @(posedge clk) begin
      a_buf_q <= a_buf_d;
      b_buf_q <= b_buf_d;
   end

   assign in_ready  = in_ready_q;
   assign arr_clear = arr_clear_q;
   assign busy      = busy_q;
   assign res_valid = res_valid_q;
   assign arr_a     = arr_a_q;
   assign arr_b     = arr_b_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with a behavioural output-stationary array model.
module tb_systolic_feeder;
   import sa_pkg::*;

   localparam int unsigned N  = SA_N;
   localparam int unsigned DW = SA_DW;
   localparam int NI = N;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            res_ready = 1'b0;
   logic [N*DW-1:0] in_a_col = '0;
   logic [N*DW-1:0] in_b_row = '0;
   logic            in_ready, arr_clear, busy, res_valid;
   logic [N*DW-1:0] arr_a, arr_b;

   always #5 clk = ~clk;

   systolic_feeder #(.N(N), .DW(DW), .DRAIN(N + 2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a_col  (in_a_col),
      .in_b_row  (in_b_row),
      .arr_clear (arr_clear),
      .arr_a     (arr_a),
      .arr_b     (arr_b),
      .busy      (busy),
      .res_valid (res_valid),
      .res_ready (res_ready)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Behavioural array: A flows right, B flows down, each PE accumulates.
   logic signed [DW-1:0] ma [N][N];
   logic signed [DW-1:0] mb [N][N];
   int                   acc [N][N];

   always @(posedge clk) begin : model
      logic signed [DW-1:0] ain, bin;
      for (int i = 0; i < NI; i++) begin
         for (int j = 0; j < NI; j++) begin
            if (j == 0) ain = $signed(arr_a[i*DW +: DW]);
            else        ain = ma[i][j-1];
            if (i == 0) bin = $signed(arr_b[j*DW +: DW]);
            else        bin = mb[i-1][j];
            if (arr_clear) begin
               ma[i][j]  <= '0;
               mb[i][j]  <= '0;
               acc[i][j] <= 0;
            end else begin
               ma[i][j]  <= ain;
               mb[i][j]  <= bin;
               acc[i][j] <= acc[i][j] + int'(ain) * int'(bin);
            end
         end
      end
   end

   // Monitor: clear pulses, accepted beats and skew snapshots at t=3 and t=14.
   int              clr_cnt = 0, acc_cnt = 0, ft = 0;
   bit              in_feed = 1'b0;
   logic [N*DW-1:0] s3a, s3b, s14a, s14b;

   always @(negedge clk) begin
      if (arr_clear) begin
         clr_cnt++;
         ft      = 0;
         in_feed = 1'b1;
      end else if (in_feed) begin
         if (ft == 3)  begin s3a  = arr_a; s3b  = arr_b; end
         if (ft == 14) begin s14a = arr_a; s14b = arr_b; end
         ft++;
         if (ft > 2 * NI - 2) in_feed = 1'b0;
      end
   end

   always @(posedge clk) begin
      if (rst_n && in_valid && in_ready) acc_cnt++;
   end

   typedef struct {
      int a_mode;   // 0: i+j+1, 1: 2*(i+j+1), 2: all -128
      int b_mode;   // 0: identity, 1: all 127, 2: all ones
      bit gaps;
      int rr_hold;  // 0: res_ready tied high, else cycles held low in DONE
      int e00;
      int e07;
      int e77;
   } vec_t;

   vec_t vecs [5];
   int   am [N][N];
   int   bm [N][N];

   task automatic set_mats(input vec_t v);
      for (int i = 0; i < NI; i++) begin
         for (int j = 0; j < NI; j++) begin
            case (v.a_mode)
               0:       am[i][j] = i + j + 1;
               1:       am[i][j] = 2 * (i + j + 1);
               default: am[i][j] = -128;
            endcase
            case (v.b_mode)
               0:       bm[i][j] = (i == j) ? 1 : 0;
               1:       bm[i][j] = 127;
               default: bm[i][j] = 1;
            endcase
         end
      end
   endtask

   function automatic logic [N*DW-1:0] exp_a(input int t);
      logic [N*DW-1:0] v = '0;
      for (int i = 0; i < NI; i++)
         if (t - i >= 0 && t - i < NI) v[i*DW +: DW] = DW'(am[i][t-i]);
      return v;
   endfunction

   function automatic logic [N*DW-1:0] exp_b(input int t);
      logic [N*DW-1:0] v = '0;
      for (int j = 0; j < NI; j++)
         if (t - j >= 0 && t - j < NI) v[j*DW +: DW] = DW'(bm[t-j][j]);
      return v;
   endfunction

   // Present N beats at negedges; gapped mode idles one cycle before each beat and
   // keeps in_valid high with junk data while the feeder is busy.
   task automatic load_job(input bit gaps);
      for (int k = 0; k < NI; k++) begin
         if (gaps) begin
            in_valid = 1'b0;
            @(negedge clk);
         end
         for (int i = 0; i < NI; i++) begin
            in_a_col[i*DW +: DW] = DW'(am[i][k]);
            in_b_row[i*DW +: DW] = DW'(bm[k][i]);
         end
         in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = gaps;
      if (gaps) begin
         in_a_col = '1;
         in_b_row = '1;
      end
   endtask

   task automatic do_job(input vec_t v);
      int  lat, errs, prod, s00, s77;
      bit  stable;
      set_mats(v);
      clr_cnt   = 0;
      acc_cnt   = 0;
      s3a       = '1; s3b  = '1;
      s14a      = '1; s14b = '1;
      res_ready = (v.rr_hold == 0);
      load_job(v.gaps);
      check("ready_drop", longint'(in_ready), 0);
      lat = 1;
      while (!res_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      in_valid = 1'b0;
      check("latency", lat, 27);
      check("busy_done", longint'(busy), 1);
      check("beats", acc_cnt, NI);
      check("clear_cycles", clr_cnt, 1);
      check("skew_a_t3", longint'(s3a), longint'(exp_a(3)));
      check("skew_b_t3", longint'(s3b), longint'(exp_b(3)));
      check("skew_a_t14", longint'(s14a), longint'(exp_a(14)));
      check("skew_b_t14", longint'(s14b), longint'(exp_b(14)));
      check("c00", acc[0][0], v.e00);
      check("c07", acc[0][7], v.e07);
      check("c77", acc[7][7], v.e77);
      errs = 0;
      for (int i = 0; i < NI; i++) begin
         for (int j = 0; j < NI; j++) begin
            prod = 0;
            for (int k = 0; k < NI; k++) prod += am[i][k] * bm[k][j];
            if (acc[i][j] != prod) errs++;
         end
      end
      check("c_full_errs", errs, 0);
      if (v.rr_hold > 0) begin
         stable = 1'b1;
         s00 = acc[0][0];
         s77 = acc[7][7];
         repeat (v.rr_hold) begin
            @(negedge clk);
            if (!res_valid || acc[0][0] != s00 || acc[7][7] != s77) stable = 1'b0;
         end
         check("hold_stable", longint'(stable), 1);
         res_ready = 1'b1;
      end
      @(negedge clk);
      check("done_exit_valid", longint'(res_valid), 0);
      check("done_exit_ready", longint'(in_ready), 1);
      res_ready = 1'b0;
   endtask

   initial begin
      vecs[0] = '{0, 0, 1'b0, 0,  1, 8, 15};
      vecs[1] = '{1, 0, 1'b0, 0,  2, 16, 30};
      vecs[2] = '{0, 0, 1'b1, 10, 1, 8, 15};
      vecs[3] = '{2, 1, 1'b0, 3,  -130048, -130048, -130048};
      vecs[4] = '{0, 2, 1'b0, 0,  36, 36, 92};

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", longint'(in_ready), 1);
      check("rst_busy", longint'(busy), 0);
      check("rst_res_valid", longint'(res_valid), 0);
      check("rst_clear", longint'(arr_clear), 0);
      check("rst_arr", longint'(arr_a | arr_b), 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int n = 0; n < 5; n++) do_job(vecs[n]);

      // Abort mid-feed at t=5, then a fresh identity job must still be exact.
      set_mats(vecs[0]);
      res_ready = 1'b0;
      load_job(1'b0);
      repeat (6) @(negedge clk);
      check("abort_pre_a_t5", longint'(arr_a), longint'(exp_a(5)));
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_arr_a", longint'(arr_a), 0);
      check("abort_arr_b", longint'(arr_b), 0);
      check("abort_busy", longint'(busy), 0);
      check("abort_in_ready", longint'(in_ready), 1);
      check("abort_clear", longint'(arr_clear), 0);
      rst_n = 1'b1;
      @(negedge clk);
      do_job(vecs[0]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
